vga_board_renderer: RTL and testbench



---
 rtl/vga_board_renderer_pkg.sv | 52 +++++
 rtl/vga_board_renderer_if.sv | 27 ++
 rtl/vga_timing_gen.sv | 59 +++++
 rtl/vga_board_renderer.sv | 204 ++++++++++++++++++++
 tb/tb_vga_board_renderer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_board_renderer_pkg.sv
// Shared battleship display definitions: colours, cell codes, game states and
// default VGA timing. Imported by vga_timing_gen and vga_board_renderer.
package battleship_definitions;

  typedef enum logic [1:0] {
    GS_SETUP  = 2'd0,
    GS_P1_WIN = 2'd1,
    GS_P2_WIN = 2'd2,
    GS_PLAY   = 2'd3
  } game_state_t;

  typedef enum logic [2:0] {
    ARR_BLANK        = 3'd0,
    ARR_SHIP         = 3'd1,
    ARR_ACTIVE_SHIP  = 3'd2,
    ARR_OVERLAP_SHIP = 3'd3,
    ARR_HIT          = 3'd4,
    ARR_MISS         = 3'd5
  } cell_code_t;

  localparam logic [7:0] COL_BLANK        = 8'hFF;
  localparam logic [7:0] COL_SHIP         = 8'h52;
  localparam logic [7:0] COL_ACTIVE_SHIP  = 8'hFC;
  localparam logic [7:0] COL_OVERLAP_SHIP = 8'hE0;
  localparam logic [7:0] COL_HIT          = 8'hC0;
  localparam logic [7:0] COL_MISS         = 8'h03;
  localparam logic [7:0] COL_BLACK        = 8'h00;
  localparam logic [7:0] COL_CURSOR       = 8'h1F;
  localparam logic [7:0] COL_WIN_BG       = 8'h1C;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_PULSE  = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_PULSE  = 2;
  localparam int DEF_V_BP     = 33;

  // Unused codes 6/7 fall through to BLANK
  function automatic logic [7:0] cell_colour(input logic [2:0] code);
    case (code)
      ARR_SHIP:         return COL_SHIP;
      ARR_ACTIVE_SHIP:  return COL_ACTIVE_SHIP;
      ARR_OVERLAP_SHIP: return COL_OVERLAP_SHIP;
      ARR_HIT:          return COL_HIT;
      ARR_MISS:         return COL_MISS;
      default:          return COL_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/vga_board_renderer_if.sv
// Game-side inputs and VGA-side outputs of the board renderer.
// master = game FSM / board pins side, slave = renderer.
interface vga_board_renderer_if #(
  parameter int GRID_N    = 10,
  parameter int CELL_BITS = 3
);
  logic                              player_turn;
  logic [GRID_N*GRID_N*CELL_BITS-1:0] p1_board;
  logic [GRID_N*GRID_N*CELL_BITS-1:0] p2_board;
  logic [1:0]                        game_state;
  logic [3:0]                        cursor_row;
  logic [3:0]                        cursor_col;
  logic                              hsync;
  logic                              vsync;
  logic [7:0]                        rgb;
  logic                              frame_start;

  modport master (
    output player_turn, p1_board, p2_board, game_state, cursor_row, cursor_col,
    input  hsync, vsync, rgb, frame_start
  );

  modport slave (
    input  player_turn, p1_board, p2_board, game_state, cursor_row, cursor_col,
    output hsync, vsync, rgb, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA h/v counters (pulse, back porch, active, front porch) with hsync, vsync
// and frame_start delayed two clocks to line up with a 2-stage pixel pipeline.
module vga_timing_gen import battleship_definitions::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_PULSE  = DEF_H_PULSE,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_PULSE  = DEF_V_PULSE,
  parameter int V_BP     = DEF_V_BP,
  localparam int H_TOTAL = H_PULSE + H_BP + H_ACTIVE + H_FP,
  localparam int V_TOTAL = V_PULSE + V_BP + V_ACTIVE + V_FP,
  localparam int HW      = $clog2(H_TOTAL + 1),
  localparam int VW      = $clog2(V_TOTAL + 1)
) (
  input  logic          clk_vga,
  input  logic          rst_n,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          h_wrap,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start
);

  logic [1:0] hs_d, vs_d, fs_d;

  assign h_wrap = (h == HW'(H_TOTAL - 1));

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (h_wrap) begin
      h <= '0;
      v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      hs_d <= '1;
      vs_d <= '1;
      fs_d <= '0;
    end else begin
      hs_d <= {hs_d[0], ~(h < HW'(H_PULSE))};
      vs_d <= {vs_d[0], ~(v < VW'(V_PULSE))};
      fs_d <= {fs_d[0], (h == '0) && (v == '0)};
    end
  end

  assign hsync       = hs_d[1];
  assign vsync       = vs_d[1];
  assign frame_start = fs_d[1];

endmodule

// File: rtl/vga_board_renderer.sv
// Renders NUM_BOARDS battleship grids with cursor and opponent mask through a
// 2-stage pixel pipeline. Optional cursor blink: define VGA_CURSOR_BLINK_EN.
module vga_board_renderer import battleship_definitions::*; #(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_PULSE    = DEF_H_PULSE,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_PULSE    = DEF_V_PULSE,
  parameter int V_BP       = DEF_V_BP,
  parameter int GRID_N     = 10,
  parameter int CELL_BITS  = 3,
  parameter int BLOCK_SIZE = 20,
  parameter int MARGIN     = 40,
  parameter int BOARD_GAP  = 40,
  parameter int HEADER     = 40,
  parameter int NUM_BOARDS = 2
) (
  input logic                  clk_vga,
  input logic                  rst_n,
  vga_board_renderer_if.slave  bus
);

  localparam int H_TOTAL = H_PULSE + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_PULSE + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int PW      = $clog2(BLOCK_SIZE);
  localparam int IW      = $clog2(GRID_N * GRID_N) + 1;
  localparam int BITS    = GRID_N * GRID_N * CELL_BITS;
  localparam int H_START = H_PULSE + H_BP;
  localparam int V_START = V_PULSE + V_BP;
  localparam int B0_X    = H_START + MARGIN;
  localparam int B1_X    = B0_X + GRID_N * BLOCK_SIZE + BOARD_GAP;
  localparam int GRID_Y  = V_START + HEADER;

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          h_wrap;
  logic          hsync_w, vsync_w, fs_w;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_PULSE (H_PULSE), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_PULSE (V_PULSE), .V_BP (V_BP)
  ) u_timing (
    .clk_vga     (clk_vga),
    .rst_n       (rst_n),
    .h           (h),
    .v           (v),
    .h_wrap      (h_wrap),
    .hsync       (hsync_w),
    .vsync       (vsync_w),
    .frame_start (fs_w)
  );

  assign bus.hsync       = hsync_w;
  assign bus.vsync       = vsync_w;
  assign bus.frame_start = fs_w;

  logic cursor_vis;
`ifdef VGA_CURSOR_BLINK_EN
  logic [5:0] frame_cnt;
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n)
      frame_cnt <= '0;
    else if (h_wrap && v == VW'(V_TOTAL - 1))
      frame_cnt <= frame_cnt + 1'b1;
  end
  assign cursor_vis = ~frame_cnt[5];
`else
  assign cursor_vis = 1'b1;
`endif

  logic [BITS-1:0] p1_snap, p2_snap;
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      p1_snap <= '0;
      p2_snap <= '0;
    end else if (h == '0 && v == '0) begin
      p1_snap <= bus.p1_board;
      p2_snap <= bus.p2_board;
    end
  end

  // Geometry registers describe the pixel at the current h/v; they are loaded
  // one count early so they stay aligned with the counters without division.
  logic          hin, hb, vin;
  logic [3:0]    hcol, vrow;
  logic [PW-1:0] hpix, vline;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      hin <= 1'b0; hb <= 1'b0; hcol <= '0; hpix <= '0;
      vin <= 1'b0; vrow <= '0; vline <= '0;
    end else begin
      if (h == HW'(B0_X - 1)) begin
        hin <= 1'b1; hb <= 1'b0; hcol <= '0; hpix <= '0;
      end else if (NUM_BOARDS > 1 && h == HW'(B1_X - 1)) begin
        hin <= 1'b1; hb <= 1'b1; hcol <= '0; hpix <= '0;
      end else if (hin) begin
        if (hpix == PW'(BLOCK_SIZE - 1)) begin
          hpix <= '0;
          if (hcol == 4'(GRID_N - 1)) hin <= 1'b0;
          else                        hcol <= hcol + 1'b1;
        end else begin
          hpix <= hpix + 1'b1;
        end
      end
      if (h_wrap) begin
        if (v == VW'(GRID_Y - 1)) begin
          vin <= 1'b1; vrow <= '0; vline <= '0;
        end else if (vin) begin
          if (vline == PW'(BLOCK_SIZE - 1)) begin
            vline <= '0;
            if (vrow == 4'(GRID_N - 1)) vin <= 1'b0;
            else                        vrow <= vrow + 1'b1;
          end else begin
            vline <= vline + 1'b1;
          end
        end
      end
    end
  end

  game_state_t    gs;
  logic           active, border, drawn, use_p2, mask, cursor_cell;
  logic [IW-1:0]  cell_idx;
  logic [2:0]     p1_cell, p2_cell, raw_code, code;

  assign gs       = game_state_t'(bus.game_state);
  assign active   = (h >= HW'(H_START)) && (h < HW'(H_START + H_ACTIVE)) &&
                    (v >= VW'(V_START)) && (v < VW'(V_START + V_ACTIVE));
  assign border   = (hpix == '0) || (hpix == PW'(BLOCK_SIZE - 1)) ||
                    (vline == '0) || (vline == PW'(BLOCK_SIZE - 1));
  assign cell_idx = IW'(vrow) * IW'(GRID_N) + IW'(hcol);
  assign p1_cell  = 3'(p1_snap[cell_idx*CELL_BITS +: CELL_BITS]);
  assign p2_cell  = 3'(p2_snap[cell_idx*CELL_BITS +: CELL_BITS]);
  assign cursor_cell = cursor_vis && (bus.cursor_row == vrow) && (bus.cursor_col == hcol) &&
                       (bus.cursor_row < 4'(GRID_N)) && (bus.cursor_col < 4'(GRID_N));

  // Board 0 is the viewer's own board in setup/play; board 1 is the opponent.
  always_comb begin
    drawn  = hin && vin && (!hb || NUM_BOARDS > 1);
    use_p2 = hb;
    mask   = 1'b0;
    case (gs)
      GS_SETUP: begin
        use_p2 = bus.player_turn;
        drawn  = drawn && !hb;
      end
      GS_PLAY: begin
        use_p2 = hb ^ bus.player_turn;
        mask   = hb;
      end
      default: use_p2 = hb;
    endcase
    raw_code = use_p2 ? p2_cell : p1_cell;
    code     = raw_code;
    if (mask && (raw_code == ARR_SHIP || raw_code == ARR_ACTIVE_SHIP ||
                 raw_code == ARR_OVERLAP_SHIP))
      code = ARR_BLANK;
  end

  logic        s1_active, s1_grid, s1_border, s1_board, s1_cursor;
  logic [2:0]  s1_code;
  game_state_t s1_state;
  logic [7:0]  rgb_q;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      s1_active <= 1'b0; s1_grid <= 1'b0; s1_border <= 1'b0;
      s1_board  <= 1'b0; s1_cursor <= 1'b0; s1_code <= '0;
      s1_state  <= GS_SETUP;
    end else begin
      s1_active <= active;
      s1_grid   <= drawn;
      s1_border <= border;
      s1_board  <= hb;
      s1_cursor <= cursor_cell;
      s1_code   <= code;
      s1_state  <= gs;
    end
  end

  logic show_cursor, win_bg;
  assign show_cursor = s1_cursor && ((s1_state == GS_SETUP && !s1_board) ||
                                     (s1_state == GS_PLAY && s1_board));
  assign win_bg      = (s1_state == GS_P1_WIN) || (s1_state == GS_P2_WIN);

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n)
      rgb_q <= COL_BLACK;
    else if (!s1_active)
      rgb_q <= COL_BLACK;
    else if (s1_grid)
      rgb_q <= s1_border ? (show_cursor ? COL_CURSOR : COL_BLACK) : cell_colour(s1_code);
    else
      rgb_q <= win_bg ? COL_WIN_BG : COL_BLACK;
  end

  assign bus.rgb = rgb_q;

endmodule

// File: tb/tb_vga_board_renderer.sv
// Directed bench for vga_board_renderer using reduced timing/geometry so that
// several frames fit in a short run; expected pixels are hand-computed.
module tb_vga_board_renderer;

  localparam int GN = 4, BS = 6;
  localparam int HA = 80, HFP = 4, HP = 8, HBP = 6;
  localparam int VA = 40, VFP = 2, VP = 2, VBP = 3;
  localparam int HT = HP + HBP + HA + HFP;   // 98
  localparam int VT = VP + VBP + VA + VFP;   // 47
  localparam int FRAME = HT * VT;            // 4606
  localparam int HS = HP + HBP;              // 14
  localparam int VS = VP + VBP;              // 5

  logic clk_vga;
  logic rst_n;
  int   checks;
  int   failures;
  int   ecnt;

  vga_board_renderer_if #(.GRID_N(GN), .CELL_BITS(3)) bus ();

  vga_board_renderer #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_PULSE (HP), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_PULSE (VP), .V_BP (VBP),
    .GRID_N (GN), .CELL_BITS (3), .BLOCK_SIZE (BS),
    .MARGIN (8), .BOARD_GAP (8), .HEADER (8), .NUM_BOARDS (2)
  ) dut (
    .clk_vga (clk_vga),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk_vga = 1'b0;
  always #5 clk_vga = ~clk_vga;

  // Rising edges since reset release, counted the same way the DUT counters advance
  always @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  // Output edge at which pixel (x,y) of frame f appears (2-clock latency)
  function automatic int pix_at(input int f, input int x, input int y);
    return f * FRAME + (VS + y) * HT + HS + x + 2;
  endfunction

  task automatic wait_edge(input int n);
    int guard;
    guard = 0;
    while (ecnt < n && guard < 20000) begin
      @(posedge clk_vga);
      #1;
      guard++;
    end
    if (ecnt != n) begin
      checks++;
      failures++;
      $display("FAIL wait_edge ecnt=%0d required=%0d", ecnt, n);
    end
  endtask

  task automatic set_cell(input bit p2, input int r, input int c, input logic [2:0] code);
    if (p2) bus.p2_board[(r*GN+c)*3 +: 3] = code;
    else    bus.p1_board[(r*GN+c)*3 +: 3] = code;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk_vga);
    #1;
    checks++;
    if ({bus.hsync, bus.vsync, bus.frame_start, bus.rgb} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_values got hs=%b vs=%b fs=%b rgb=%h exp hs=1 vs=1 fs=0 rgb=00",
               bus.hsync, bus.vsync, bus.frame_start, bus.rgb);
    end
    @(negedge clk_vga);
    rst_n = 1'b1;
    wait_edge(1);
    checks++;
    if (bus.hsync !== 1'b1) begin
      failures++; $display("FAIL hsync_cycle1 got=%b exp=1", bus.hsync);
    end
    wait_edge(2);
    checks++;
    if ({bus.hsync, bus.vsync, bus.frame_start} !== 3'b001) begin
      failures++;
      $display("FAIL sync_cycle2 got hs=%b vs=%b fs=%b exp hs=0 vs=0 fs=1",
               bus.hsync, bus.vsync, bus.frame_start);
    end
    wait_edge(3);
    checks++;
    if (bus.frame_start !== 1'b0) begin
      failures++; $display("FAIL frame_start_pulse got=%b exp=0", bus.frame_start);
    end
  endtask

  task automatic test_sync_timing();
    int   e[6]   = '{9, 10, 99, 100, 197, 198};
    bit   isv[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic ex[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic got;
    for (int i = 0; i < 6; i++) begin
      wait_edge(e[i]);
      got = isv[i] ? bus.vsync : bus.hsync;
      checks++;
      if (got !== ex[i]) begin
        failures++;
        $display("FAIL sync_edge_%0d %s got=%b exp=%b", e[i], isv[i] ? "vsync" : "hsync", got, ex[i]);
      end
    end
  endtask

  task automatic test_setup_board();
    int         px[6] = '{2, 8, 9, 45, 14, 16};
    int         py[6] = '{2, 9, 9, 10, 16, 16};
    logic [7:0] pe[6] = '{8'h00, 8'h00, 8'h52, 8'h00, 8'h1F, 8'hFF};
    for (int i = 0; i < 6; i++) begin
      wait_edge(pix_at(0, px[i], py[i]));
      checks++;
      if (bus.rgb !== pe[i]) begin
        failures++;
        $display("FAIL setup_pix(%0d,%0d) got=%h exp=%h", px[i], py[i], bus.rgb, pe[i]);
      end
    end
    bus.player_turn = 1'b1;
    wait_edge(pix_at(0, 27, 21));
    checks++;
    if (bus.rgb !== 8'h52) begin
      failures++; $display("FAIL setup_p2_own(27,21) got=%h exp=52", bus.rgb);
    end
    bus.player_turn = 1'b0;
  endtask

  task automatic test_frame_period();
    wait_edge(FRAME + 1);
    checks++;
    if (bus.frame_start !== 1'b0) begin
      failures++; $display("FAIL frame_start_early got=%b exp=0", bus.frame_start);
    end
    wait_edge(FRAME + 2);
    checks++;
    if (bus.frame_start !== 1'b1) begin
      failures++; $display("FAIL frame_start_period got=%b exp=1", bus.frame_start);
    end
  endtask

  task automatic test_play_masking();
    int         px[3] = '{58, 59, 63};
    int         py[3] = '{21, 21, 23};
    logic [7:0] pe[3] = '{8'h1F, 8'hFF, 8'h1F};
    bus.game_state = 2'd3;
    bus.cursor_row = 4'd2;
    bus.cursor_col = 4'd3;
    wait_edge(pix_at(1, 9, 9));
    checks++;
    if (bus.rgb !== 8'h52) begin
      failures++; $display("FAIL play_own(9,9) got=%h exp=52", bus.rgb);
    end
    set_cell(1'b1, 2, 3, 3'd4);
    for (int i = 0; i < 3; i++) begin
      wait_edge(pix_at(1, px[i], py[i]));
      checks++;
      if (bus.rgb !== pe[i]) begin
        failures++;
        $display("FAIL play_pix(%0d,%0d) got=%h exp=%h", px[i], py[i], bus.rgb, pe[i]);
      end
    end
  endtask

  task automatic test_snapshot_next_frame();
    int         px[3] = '{58, 59, 63};
    int         py[3] = '{21, 21, 23};
    logic [7:0] pe[3] = '{8'h00, 8'hC0, 8'h00};
    bus.cursor_row = 4'd4;
    for (int i = 0; i < 3; i++) begin
      wait_edge(pix_at(2, px[i], py[i]));
      checks++;
      if (bus.rgb !== pe[i]) begin
        failures++;
        $display("FAIL next_frame_pix(%0d,%0d) got=%h exp=%h", px[i], py[i], bus.rgb, pe[i]);
      end
    end
    set_cell(1'b0, 1, 0, 3'd7);
    set_cell(1'b1, 0, 0, 3'd1);
    bus.game_state = 2'd2;
    bus.cursor_row = 4'd0;
    bus.cursor_col = 4'd0;
  endtask

  task automatic test_win_state();
    int         px[7] = '{2, 79, 82, 41, 8, 9, 59};
    int         py[7] = '{2, 2, 2, 9, 10, 15, 21};
    logic [7:0] pe[7] = '{8'h1C, 8'h1C, 8'h00, 8'h52, 8'h00, 8'hFF, 8'hC0};
    for (int i = 0; i < 7; i++) begin
      wait_edge(pix_at(3, px[i], py[i]));
      checks++;
      if (bus.rgb !== pe[i]) begin
        failures++;
        $display("FAIL win_pix(%0d,%0d) got=%h exp=%h", px[i], py[i], bus.rgb, pe[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    wait_edge(pix_at(3, 2, 25));
    checks++;
    if (bus.rgb !== 8'h1C) begin
      failures++; $display("FAIL pre_reset_pix got=%h exp=1c", bus.rgb);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.hsync, bus.vsync, bus.frame_start, bus.rgb} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL async_reset got hs=%b vs=%b fs=%b rgb=%h exp hs=1 vs=1 fs=0 rgb=00",
               bus.hsync, bus.vsync, bus.frame_start, bus.rgb);
    end
    repeat (2) @(posedge clk_vga);
    @(negedge clk_vga);
    rst_n = 1'b1;
    wait_edge(2);
    checks++;
    if ({bus.hsync, bus.frame_start, bus.rgb} !== {1'b0, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL restart got hs=%b fs=%b rgb=%h exp hs=0 fs=1 rgb=00",
               bus.hsync, bus.frame_start, bus.rgb);
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    bus.player_turn = 1'b0;
    bus.game_state  = 2'd0;
    bus.cursor_row  = 4'd1;
    bus.cursor_col  = 4'd1;
    bus.p1_board    = '0;
    bus.p2_board    = '0;
    set_cell(1'b0, 0, 0, 3'd1);
    set_cell(1'b1, 2, 3, 3'd1);

    test_reset();
    test_sync_timing();
    test_setup_board();
    test_frame_period();
    test_play_masking();
    test_snapshot_next_frame();
    test_win_state();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
